// File: rtl/motion_sensor_frontend.sv
// PIR sensor conditioning: 2-flop sync, debounce, post-release hold-off, onset pulse.
// Optional saturating event counter enabled by defining MOTION_EVENT_CNT_EN.
//
// state   | meaning
// IDLE    | waiting for synced input high
// QUALIFY | counting consecutive high samples
// ACTIVE  | motion qualified, motion_detected high
// HOLDOFF | input ignored after release
module motion_sensor_frontend #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 8,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pir_raw,
  output logic             motion_detected,
  output logic             motion_pulse,
  output logic [CNT_W-1:0] event_count
);

  localparam int MAX_CYC = (DEBOUNCE_CYCLES > HOLDOFF_CYCLES) ? DEBOUNCE_CYCLES : HOLDOFF_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] DEB_TERM = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] HOL_TERM = CW'(HOLDOFF_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] QUALIFY = 2'd1;
  localparam logic [1:0] ACTIVE  = 2'd2;
  localparam logic [1:0] HOLDOFF = 2'd3;

  logic          s1_q, s2_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          det_q, det_d;
  logic          pulse_q, pulse_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pir_raw;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    det_d   = det_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ACTIVE;
            cnt_d   = '0;
            det_d   = 1'b1;
            pulse_d = 1'b1;
          end else begin
            state_d = QUALIFY;
            cnt_d   = CNT_ONE;
          end
        end
      end
      QUALIFY: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q + CNT_ONE == DEB_TERM) begin
          state_d = ACTIVE;
          cnt_d   = '0;
          det_d   = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ACTIVE: begin
        det_d = 1'b1;
        if (!s2_q) begin
          state_d = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
          cnt_d   = '0;
          det_d   = 1'b0;
        end
      end
      HOLDOFF: begin
        det_d = 1'b0;
        if (cnt_q + CNT_ONE == HOL_TERM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        det_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      det_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      det_q   <= det_d;
      pulse_q <= pulse_d;
    end
  end

  assign motion_detected = det_q;
  assign motion_pulse    = pulse_q;

`ifdef MOTION_EVENT_CNT_EN
  logic [CNT_W-1:0] evt_q;

  // Saturates at all-ones; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_q <= '0;
    end else if (pulse_q && (evt_q != {CNT_W{1'b1}})) begin
      evt_q <= evt_q + CNT_W'(1);
    end
  end

  assign event_count = evt_q;
`else
  assign event_count = '0;
`endif

endmodule

// File: tb/tb_motion_sensor_frontend.sv
// Directed bench for motion_sensor_frontend: reset, onset latency, release, hold-off,
// glitch rejection, event counter saturation (CNT_W=2 when MOTION_EVENT_CNT_EN) and mid-ACTIVE reset.
module tb_motion_sensor_frontend;

`ifdef MOTION_EVENT_CNT_EN
  localparam int TB_CNT_W = 2;
`else
  localparam int TB_CNT_W = 16;
`endif

  logic                clk;
  logic                rst_n;
  logic                pir_raw;
  logic                motion_detected;
  logic                motion_pulse;
  logic [TB_CNT_W-1:0] event_count;

  int checks = 0;
  int errors = 0;

  motion_sensor_frontend #(
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_CYCLES (8),
    .CNT_W          (TB_CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pir_raw        (pir_raw),
    .motion_detected(motion_detected),
    .motion_pulse   (motion_pulse),
    .event_count    (event_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_ec(input int n);
`ifdef MOTION_EVENT_CNT_EN
    return (n > 3) ? 32'd3 : 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  // Input held high from the next posedge; expects motion_detected exactly after posedge 6.
  task automatic qualify(input string tag, input int n_evt);
    pir_raw = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check({tag, "_det_pre"}, 32'(motion_detected), 32'd0);
      check({tag, "_pulse_pre"}, 32'(motion_pulse), 32'd0);
    end
    tick();
    check({tag, "_det_on"}, 32'(motion_detected), 32'd1);
    check({tag, "_pulse_on"}, 32'(motion_pulse), 32'd1);
    tick();
    check({tag, "_det_hold"}, 32'(motion_detected), 32'd1);
    check({tag, "_pulse_once"}, 32'(motion_pulse), 32'd0);
    check({tag, "_count"}, 32'(event_count), exp_ec(n_evt));
  endtask

  // From ACTIVE: drop input, verify 3-edge release, then run out the hold-off.
  task automatic release_and_wait(input string tag);
    pir_raw = 1'b0;
    tick();
    check({tag, "_rel1"}, 32'(motion_detected), 32'd1);
    tick();
    check({tag, "_rel2"}, 32'(motion_detected), 32'd1);
    tick();
    check({tag, "_rel3"}, 32'(motion_detected), 32'd0);
    repeat (11) tick();
    check({tag, "_idle"}, 32'(motion_detected), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    pir_raw = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_det", 32'(motion_detected), 32'd0);
      check("rst_pulse", 32'(motion_pulse), 32'd0);
      check("rst_count", 32'(event_count), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("rel_det", 32'(motion_detected), 32'd0);
    check("rel_pulse", 32'(motion_pulse), 32'd0);
    check("rel_count", 32'(event_count), 32'd0);

    // Short post-reset high is a sub-debounce glitch; let it flush.
    pir_raw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("flush_det", 32'(motion_detected), 32'd0);
    end

    qualify("onset", 1);

    // One-cycle drop in ACTIVE, then held high through hold-off.
    pir_raw = 1'b0;
    tick();
    check("ho_d1", 32'(motion_detected), 32'd1);
    pir_raw = 1'b1;
    tick();
    check("ho_d2", 32'(motion_detected), 32'd1);
    tick();
    check("ho_fall", 32'(motion_detected), 32'd0);
    for (int i = 0; i < 11; i++) begin
      tick();
      check("ho_low_det", 32'(motion_detected), 32'd0);
      check("ho_low_pulse", 32'(motion_pulse), 32'd0);
    end
    tick();
    check("ho_reassert", 32'(motion_detected), 32'd1);
    check("ho_pulse2", 32'(motion_pulse), 32'd1);
    tick();
    check("ho_pulse2_end", 32'(motion_pulse), 32'd0);
    check("ho_count", 32'(event_count), exp_ec(2));

    release_and_wait("r1");

    pir_raw = 1'b1;
    repeat (3) tick();
    pir_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("glitch_det", 32'(motion_detected), 32'd0);
      check("glitch_pulse", 32'(motion_pulse), 32'd0);
    end

    qualify("post_glitch", 3);
    release_and_wait("r2");
    qualify("evt4", 4);
    release_and_wait("r3");
    qualify("evt5", 5);

    rst_n = 1'b0;
    tick();
    check("midrst_det", 32'(motion_detected), 32'd0);
    check("midrst_pulse", 32'(motion_pulse), 32'd0);
    check("midrst_count", 32'(event_count), 32'd0);
    rst_n = 1'b1;
    qualify("requal", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
